// File: rtl/bsg_manycore_status_sender_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_manycore_status_sender_pkg
//  Purpose  : Shared definitions for the manycore I/O status protocol:
//             status opcodes, monitor word addresses and packet layout.
//  Revision : 1.0  initial release
// ============================================================================
package bsg_manycore_status_sender_pkg;

  // Status request opcodes as presented on req_op_i.
  typedef enum logic [1:0] {
    STATUS_OP_FINISH = 2'd0,
    STATUS_OP_TIME   = 2'd1,
    STATUS_OP_FAIL   = 2'd2,
    STATUS_OP_PRINT  = 2'd3
  } status_op_e;

  // Network packet opcode field.
  localparam int                      PKT_OP_WIDTH        = 2;
  localparam logic [PKT_OP_WIDTH-1:0] PKT_OP_REMOTE_STORE = 2'b01;

  // Monitor word addresses; shared with the I/O monitor decoder.
  localparam logic [31:0] STATUS_FINISH_ADDR = 32'h0003_7AB0;
  localparam logic [31:0] STATUS_TIME_ADDR   = 32'h0003_7AB1;
  localparam logic [31:0] STATUS_FAIL_ADDR   = 32'h0003_7AB2;

  // Packet layout, MSB to LSB:
  //   { data[data_w], addr[addr_w], op[2], mask[data_w/8],
  //     src_y[y_w], src_x[x_w], dest_y[y_w], dest_x[x_w] }
  function automatic int status_packet_width(input int x_w, input int y_w,
                                             input int addr_w, input int data_w);
    return data_w + addr_w + PKT_OP_WIDTH + (data_w / 8) + 2 * (x_w + y_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_manycore_credit_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_manycore_credit_counter
//  Purpose  : Up/down saturating credit counter with a reset value.
//             Simultaneous up and down leave the count unchanged.
//  Revision : 1.0  initial release
// ============================================================================
module bsg_manycore_credit_counter #(
  parameter int width_p    = 5,
  parameter int max_val_p  = 16,
  parameter int init_val_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o
);

  localparam logic [width_p-1:0] max_lp  = width_p'(max_val_p);
  localparam logic [width_p-1:0] init_lp = width_p'(init_val_p);

  logic [width_p-1:0] count;

  // Count returned credits up and spent credits down, clamping at both ends.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count <= init_lp;
    end else if (up_i && !down_i) begin
      if (count != max_lp) count <= count + 1'b1;
    end else if (down_i && !up_i) begin
      if (count != '0) count <= count - 1'b1;
    end
  end

  // A credit returned while already full means the peer over-acknowledged.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && up_i && !down_i) begin
      assert (count != max_lp)
        else $error("bsg_manycore_credit_counter: credit returned while counter is full");
    end
  end

  assign count_o = count;

endmodule
`default_nettype wire

// File: rtl/bsg_manycore_status_sender.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_manycore_status_sender
//  Purpose  : Turns FINISH/TIME/FAIL/PRINT requests into remote-store packets
//             for the I/O monitor. FINISH/FAIL wait until all earlier stores
//             are acknowledged before leaving.
//  Revision : 1.0  initial release
// ============================================================================
module bsg_manycore_status_sender
  import bsg_manycore_status_sender_pkg::*;
#(
  parameter int x_cord_width_p    = 4,
  parameter int y_cord_width_p    = 4,
  parameter int addr_width_p      = 20,
  parameter int data_width_p      = 32,
  parameter int max_out_credits_p = 16,
  localparam int packet_width_lp  = status_packet_width(x_cord_width_p, y_cord_width_p,
                                                        addr_width_p, data_width_p),
  localparam int credit_width_lp  = $clog2(max_out_credits_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,

  input  logic                       req_v_i,
  input  logic [1:0]                 req_op_i,
  input  logic [addr_width_p-1:0]    req_addr_i,
  input  logic [data_width_p-1:0]    req_data_i,
  output logic                       req_ready_o,

  input  logic [x_cord_width_p-1:0]  my_x_i,
  input  logic [y_cord_width_p-1:0]  my_y_i,
  input  logic [x_cord_width_p-1:0]  dest_x_i,
  input  logic [y_cord_width_p-1:0]  dest_y_i,

  output logic                       pkt_v_o,
  output logic [packet_width_lp-1:0] pkt_o,
  input  logic                       pkt_ready_i,

  input  logic                       credit_v_i,
  output logic [credit_width_lp-1:0] out_credits_o,
  output logic                       done_o,
  output logic                       failed_o
);

  localparam int mask_width_lp = data_width_p / 8;
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FENCE = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]                 state;
  logic [1:0]                 state_next;
  logic [credit_width_lp-1:0] credits;
  logic                       credits_full;
  logic                       accept;
  logic                       pkt_handshake;
  logic                       req_is_terminal;
  logic                       req_is_fail;
  logic [addr_width_p-1:0]    req_word_addr;
  logic [data_width_p-1:0]    req_payload;
  logic [data_width_p-1:0]    status_payload;
  logic [packet_width_lp-1:0] pkt_next;
  logic [packet_width_lp-1:0] pkt_q;
  logic                       is_terminal_q;
  logic                       is_fail_q;

  bsg_manycore_credit_counter #(
    .width_p    (credit_width_lp),
    .max_val_p  (max_out_credits_p),
    .init_val_p (max_out_credits_p)
  ) credit_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .up_i      (credit_v_i),
    .down_i    (pkt_handshake),
    .count_o   (credits)
  );

  assign credits_full    = (credits == max_credits_lp);
  assign accept          = req_v_i & req_ready_o;
  assign pkt_handshake   = pkt_v_o & pkt_ready_i;
  assign req_is_terminal = (req_op_i == STATUS_OP_FINISH) || (req_op_i == STATUS_OP_FAIL);
  assign req_is_fail     = (req_op_i == STATUS_OP_FAIL);
  assign status_payload  = data_width_p'({16'(my_y_i), 16'(my_x_i)});

  // Build the packet for the request currently offered on the input side.
  always_comb begin
    req_word_addr = req_addr_i;
    req_payload   = req_data_i;
    case (status_op_e'(req_op_i))
      STATUS_OP_FINISH: begin
        req_word_addr = addr_width_p'(STATUS_FINISH_ADDR);
        req_payload   = status_payload;
      end
      STATUS_OP_TIME: begin
        req_word_addr = addr_width_p'(STATUS_TIME_ADDR);
        req_payload   = status_payload;
      end
      STATUS_OP_FAIL: begin
        req_word_addr = addr_width_p'(STATUS_FAIL_ADDR);
        req_payload   = status_payload;
      end
      default: ;
    endcase
    pkt_next = {req_payload, req_word_addr, PKT_OP_REMOTE_STORE, {mask_width_lp{1'b1}},
                my_y_i, my_x_i, dest_y_i, dest_x_i};
  end

  // Capture the packet at accept; it stays frozen until the handshake.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pkt_q         <= '0;
      is_terminal_q <= 1'b0;
      is_fail_q     <= 1'b0;
    end else if (accept) begin
      pkt_q         <= pkt_next;
      is_terminal_q <= req_is_terminal;
      is_fail_q     <= req_is_fail;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= ST_IDLE;
    else            state <= state_next;
  end

  // Next-state logic. A terminal request arriving with every credit already
  // home has nothing to fence against, so it goes straight to SEND.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_is_terminal && !credits_full) state_next = ST_FENCE;
          else                                  state_next = ST_SEND;
        end
      end
      ST_FENCE: if (credits_full)  state_next = ST_SEND;
      ST_SEND:  if (pkt_handshake) state_next = is_terminal_q ? ST_DONE : ST_IDLE;
      ST_DONE:  state_next = ST_DONE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; valid is gated so credits never underflow.
  always_comb begin
    req_ready_o = (state == ST_IDLE);
    pkt_v_o     = (state == ST_SEND) && (credits != '0);
    done_o      = (state == ST_DONE);
    failed_o    = (state == ST_DONE) && is_fail_q;
  end

  assign pkt_o         = pkt_q;
  assign out_credits_o = credits;

endmodule
`default_nettype wire

// File: tb/tb_bsg_manycore_status_sender.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bsg_manycore_status_sender
//  Purpose  : Self-checking bench for the status sender (16-credit and
//             2-credit instances).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bsg_manycore_status_sender;
  import bsg_manycore_status_sender_pkg::*;

  localparam int XW   = 4;
  localparam int YW   = 4;
  localparam int AW   = 20;
  localparam int DW   = 32;
  localparam int MAXA = 16;
  localparam int MAXB = 2;
  localparam int PW   = status_packet_width(XW, YW, AW, DW);
  localparam int CWA  = $clog2(MAXA + 1);
  localparam int CWB  = $clog2(MAXB + 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A (16 credits)
  logic          req_v = 1'b0;
  logic [1:0]    req_op = 2'd0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          req_ready;
  logic [XW-1:0] my_x = '0, dest_x = '0;
  logic [YW-1:0] my_y = '0, dest_y = '0;
  logic          pkt_v;
  logic [PW-1:0] pkt;
  logic          pkt_ready = 1'b1;
  logic          credit_v = 1'b0;
  logic [CWA-1:0] credits;
  logic          done, failed;

  // Instance B (2 credits)
  logic          b_req_v = 1'b0;
  logic [1:0]    b_req_op = 2'd3;
  logic [AW-1:0] b_req_addr = 20'h00040;
  logic [DW-1:0] b_req_data = 32'h1234_5678;
  logic          b_req_ready;
  logic [XW-1:0] b_x = '0;
  logic [YW-1:0] b_y = '0;
  logic          b_pkt_v;
  logic [PW-1:0] b_pkt;
  logic          b_pkt_ready = 1'b1;
  logic          b_credit_v = 1'b0;
  logic [CWB-1:0] b_credits;
  logic          b_done, b_failed;

  bsg_manycore_status_sender #(
    .x_cord_width_p(XW), .y_cord_width_p(YW), .addr_width_p(AW),
    .data_width_p(DW), .max_out_credits_p(MAXA)
  ) dut_a (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_v_i(req_v), .req_op_i(req_op), .req_addr_i(req_addr), .req_data_i(req_data),
    .req_ready_o(req_ready),
    .my_x_i(my_x), .my_y_i(my_y), .dest_x_i(dest_x), .dest_y_i(dest_y),
    .pkt_v_o(pkt_v), .pkt_o(pkt), .pkt_ready_i(pkt_ready),
    .credit_v_i(credit_v), .out_credits_o(credits), .done_o(done), .failed_o(failed)
  );

  bsg_manycore_status_sender #(
    .x_cord_width_p(XW), .y_cord_width_p(YW), .addr_width_p(AW),
    .data_width_p(DW), .max_out_credits_p(MAXB)
  ) dut_b (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_v_i(b_req_v), .req_op_i(b_req_op), .req_addr_i(b_req_addr), .req_data_i(b_req_data),
    .req_ready_o(b_req_ready),
    .my_x_i(b_x), .my_y_i(b_y), .dest_x_i(b_x), .dest_y_i(b_y),
    .pkt_v_o(b_pkt_v), .pkt_o(b_pkt), .pkt_ready_i(b_pkt_ready),
    .credit_v_i(b_credit_v), .out_credits_o(b_credits), .done_o(b_done), .failed_o(b_failed)
  );

  int checks = 0;
  int failures = 0;
  int dut_sent = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h @%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] f_addr(input logic [PW-1:0] p);
    return p[PW-DW-1 -: AW];
  endfunction

  function automatic logic [DW-1:0] f_data(input logic [PW-1:0] p);
    return p[PW-1 -: DW];
  endfunction

  // Expected packet from the request fields and current coordinates.
  function automatic logic [PW-1:0] build_pkt(input logic [1:0] op, input logic [AW-1:0] a,
                                              input logic [DW-1:0] d);
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    wd = DW'(my_y) * 65536 + DW'(my_x);
    case (op)
      2'd0:    wa = 20'h37AB0;
      2'd1:    wa = 20'h37AB1;
      2'd2:    wa = 20'h37AB2;
      default: begin wa = a; wd = d; end
    endcase
    return {wd, wa, PKT_OP_REMOTE_STORE, {(DW/8){1'b1}}, my_y, my_x, dest_y, dest_x};
  endfunction

  // ---------------- behavioural model of instance A ----------------
  // Cycles are numbered at each falling edge. A request accepted in cycle N
  // may be offered from cycle N+1; a FINISH/FAIL only from the cycle after
  // the first cycle (>= N) in which all credits were home.
  int            cyc = 0;
  bit            m_busy = 0, m_term = 0, m_fail_op = 0, m_done = 0, m_failed = 0;
  int            m_acc_cyc = 0, m_full_cyc = -1, m_cred = MAXA;
  logic [PW-1:0] m_pkt = '0;
  bit            exp_valid, exp_ready, m_hs;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      m_busy = 0; m_done = 0; m_failed = 0; m_cred = MAXA; m_full_cyc = -1;
      exp_valid = 0; exp_ready = 1;
    end else begin
      if (m_busy && m_term && m_full_cyc < 0 && m_cred == MAXA) m_full_cyc = cyc;
      exp_valid = m_busy && (m_cred > 0) &&
                  (m_term ? (m_full_cyc >= 0 && cyc > m_full_cyc) : (cyc > m_acc_cyc));
      exp_ready = !m_busy && !m_done;
    end
    chk("req_ready", req_ready, exp_ready);
    chk("pkt_v", pkt_v, exp_valid);
    chk("credits", credits, m_cred);
    chk("done", done, m_done);
    chk("failed", failed, m_failed);
    if (exp_valid && pkt_v) chk("pkt", pkt, m_pkt);
    if (reset_n) begin
      if (pkt_v && pkt_ready) dut_sent++;
      m_hs = exp_valid && pkt_ready;
      if (exp_ready && req_v) begin
        m_busy     = 1;
        m_acc_cyc  = cyc;
        m_term     = (req_op == 2'd0) || (req_op == 2'd2);
        m_fail_op  = (req_op == 2'd2);
        m_pkt      = build_pkt(req_op, req_addr, req_data);
        m_full_cyc = (m_cred == MAXA) ? cyc : -1;
      end
      if (m_hs) begin
        m_busy = 0;
        if (m_term) begin m_done = 1; m_failed = m_fail_op; end
      end
      m_cred = m_cred + int'(credit_v) - int'(m_hs);
      if (m_cred > MAXA) m_cred = MAXA;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req_a(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    req_v = 1'b1; req_op = op; req_addr = a; req_data = d;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_accept_timeout", req_ready, 1'b1);
    @(posedge clk); #1;
    req_v = 1'b0;
  endtask

  task automatic wait_pkt_a(output logic [PW-1:0] p);
    int n;
    n = 0;
    @(negedge clk);
    while (!(pkt_v && pkt_ready) && n < 50) begin @(negedge clk); n++; end
    chk("pkt_wait_timeout", pkt_v && pkt_ready, 1'b1);
    p = pkt;
    @(posedge clk); #1;
  endtask

  task automatic return_credits(input int n);
    credit_v = 1'b1;
    step(n);
    credit_v = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  logic [PW-1:0] cap;
  int s0;

  initial begin
    // 1: reset, TIME packet
    my_x = 4'd3; my_y = 4'd2; dest_x = 4'd0; dest_y = 4'd0;
    step(2);
    chk("rst_credits", credits, 5'd16);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_pkt_v", pkt_v, 1'b0);
    chk("rst_done", done, 1'b0);
    reset_n = 1'b1;
    step(1);
    req_a(2'd1, '0, '0);
    chk("time_first_cycle_valid", pkt_v, 1'b1);
    wait_pkt_a(cap);
    chk("time_addr", f_addr(cap), 20'h37AB1);
    chk("time_data", f_data(cap), 32'h0002_0003);
    chk("time_credits_15", credits, 5'd15);
    return_credits(1);
    chk("time_credits_16", credits, 5'd16);

    // 2: PRINT with network back-pressure
    pkt_ready = 1'b0;
    req_a(2'd3, 20'h01000, 32'h0000_CAFE);
    s0 = dut_sent;
    repeat (5) begin
      @(negedge clk);
      chk("print_held_valid", pkt_v, 1'b1);
    end
    @(posedge clk); #1;
    pkt_ready = 1'b1;
    wait_pkt_a(cap);
    chk("print_sent_once", dut_sent - s0, 1);
    chk("print_addr", f_addr(cap), 20'h01000);
    chk("print_data", f_data(cap), 32'h0000_CAFE);
    step(2);
    chk("print_no_resend", dut_sent - s0, 1);
    return_credits(1);

    // 3: FINISH fenced behind four outstanding PRINTs
    for (int i = 0; i < 4; i++) begin
      req_a(2'd3, AW'(20'h00100 + i), DW'(32'hA0 + i));
      wait_pkt_a(cap);
    end
    chk("fence_credits_12", credits, 5'd12);
    req_a(2'd0, '0, '0);
    step(3);
    chk("fence_holds", pkt_v, 1'b0);
    return_credits(4);
    chk("fence_full", credits, 5'd16);
    chk("fence_not_yet", pkt_v, 1'b0);
    step(1);
    chk("finish_valid_next", pkt_v, 1'b1);
    cap = pkt;
    step(1);
    chk("finish_addr", f_addr(cap), 20'h37AB0);
    chk("finish_done", done, 1'b1);
    chk("finish_failed", failed, 1'b0);
    chk("finish_ready", req_ready, 1'b0);
    chk("finish_credits", credits, 5'd15);
    return_credits(1);
    chk("done_credit_counted", credits, 5'd16);
    chk("done_sticky", done, 1'b1);

    // 5: simultaneous handshake and credit return, then FAIL
    do_reset();
    req_a(2'd1, '0, '0);
    wait_pkt_a(cap);
    req_a(2'd3, 20'h02222, 32'h0BAD_F00D);
    s0 = dut_sent;
    credit_v = 1'b1;
    step(1);
    credit_v = 1'b0;
    chk("simul_sent", dut_sent - s0, 1);
    chk("simul_credits", credits, 5'd15);
    return_credits(1);
    req_a(2'd2, '0, '0);
    wait_pkt_a(cap);
    chk("fail_addr", f_addr(cap), 20'h37AB2);
    chk("fail_data", f_data(cap), 32'h0002_0003);
    chk("fail_failed", failed, 1'b1);
    chk("fail_done", done, 1'b1);
    chk("fail_ready", req_ready, 1'b0);

    // 6: reset during FENCE and during SEND
    do_reset();
    req_a(2'd3, 20'h00300, 32'h3);
    wait_pkt_a(cap);
    req_a(2'd0, '0, '0);
    step(2);
    chk("midfence_pkt_v", pkt_v, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midfence_rst_credits", credits, 5'd16);
    chk("midfence_rst_ready", req_ready, 1'b1);
    step(1);
    reset_n = 1'b1;
    pkt_ready = 1'b0;
    req_a(2'd3, 20'h00400, 32'h4);
    step(1);
    chk("midsend_valid", pkt_v, 1'b1);
    s0 = dut_sent;
    reset_n = 1'b0;
    #1;
    chk("midsend_rst_pkt_v", pkt_v, 1'b0);
    chk("midsend_rst_credits", credits, 5'd16);
    step(1);
    reset_n = 1'b1;
    pkt_ready = 1'b1;
    step(3);
    chk("midsend_dropped", dut_sent - s0, 0);
    chk("midsend_idle_pkt_v", pkt_v, 1'b0);

    // 4: two-credit instance, third PRINT stalls until a credit returns
    chk("b_init_credits", b_credits, 2'd2);
    for (int i = 0; i < 3; i++) begin
      b_req_v = 1'b1;
      @(negedge clk);
      chk("b_ready", b_req_ready, 1'b1);
      @(posedge clk); #1;
      b_req_v = 1'b0;
      if (i < 2) begin
        @(negedge clk);
        chk("b_send_valid", b_pkt_v, 1'b1);
        chk("b_send_addr", f_addr(b_pkt), 20'h00040);
        @(posedge clk); #1;
      end
    end
    chk("b_credits_0", b_credits, 2'd0);
    repeat (3) begin
      @(negedge clk);
      chk("b_stall", b_pkt_v, 1'b0);
    end
    @(posedge clk); #1;
    b_credit_v = 1'b1;
    @(negedge clk);
    chk("b_stall_credit_cycle", b_pkt_v, 1'b0);
    @(posedge clk); #1;
    b_credit_v = 1'b0;
    @(negedge clk);
    chk("b_resume_valid", b_pkt_v, 1'b1);
    chk("b_resume_credits", b_credits, 2'd1);
    @(posedge clk); #1;
    chk("b_after_credits", b_credits, 2'd0);
    chk("b_after_ready", b_req_ready, 1'b1);
    chk("b_not_done", b_done | b_failed, 1'b0);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
